// File: rtl/mips32_program_sequencer_pkg.sv
// Shared types and constants for the MIPS32 program sequencer.
package mips32_seq_pkg;

    // Sequencer FSM states, also exported on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_CHECK  = 3'd3,
        ST_PAUSE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Instruction driven to the core whenever no program entry is active.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Default parameter values.
    localparam int DEF_INSTR_W  = 32;
    localparam int DEF_RESULT_W = 32;
    localparam int DEF_DEPTH    = 64;
    localparam int DEF_SETTLE   = 1;
    localparam int DEF_CNT_W    = 16;

endpackage

// File: rtl/mips32_program_sequencer_if.sv
// Program-load bus and core instruction/result bus of the sequencer.
//
// Bus semantics: there is no ready signal. instr_valid=1 qualifies
// `instruction` as a program entry; it stays stable from ISSUE through
// CHECK. The core must present `result` combinationally, and the
// sequencer samples it on the clock edge that ends CHECK. A load write
// (load_en=1) is taken on the rising edge only while the sequencer is
// not busy; otherwise it is dropped.
interface mips32_program_sequencer_if #(
    parameter int INSTR_W  = 32,
    parameter int RESULT_W = 32,
    parameter int ADDR_W   = 6
);
    logic                load_en;
    logic [ADDR_W-1:0]   load_addr;
    logic [INSTR_W-1:0]  load_instr;
    logic [RESULT_W-1:0] load_expect;
    logic                load_check;

    logic [INSTR_W-1:0]  instruction;
    logic                instr_valid;
    logic [RESULT_W-1:0] result;

    // Sequencer side.
    modport master (
        input  load_en, load_addr, load_instr, load_expect, load_check, result,
        output instruction, instr_valid
    );

    // Loader / core side.
    modport slave (
        output load_en, load_addr, load_instr, load_expect, load_check, result,
        input  instruction, instr_valid
    );
endinterface

// File: rtl/mips32_program_sequencer_mem.sv
// Program storage: synchronous write, asynchronous read, no reset.
module mips32_prog_mem #(
    parameter int DEPTH  = 64,
    parameter int W      = 65,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [W-1:0]      o_rdata
);
    logic [W-1:0] r_mem [DEPTH];

    // Write port: one entry per cycle when enabled.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mips32_program_sequencer.sv
// Issues stored instructions to the core, checks results, keeps stats.
module mips32_program_sequencer
    import mips32_seq_pkg::*;
#(
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int RESULT_W = DEF_RESULT_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int SETTLE   = DEF_SETTLE,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    mips32_program_sequencer_if.master bus,
    input  logic [ADDR_W:0]     prog_len,
    input  logic                start,
    input  logic                abort,
    input  logic                step_mode,
    input  logic                step,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    fail_count,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [CNT_W-1:0]    cycle_count,
    output state_t              o_dbg_state
);
    localparam int MEM_W = INSTR_W + RESULT_W + 1;
    localparam int SC_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [SC_W-1:0]     r_settle;
    logic [CNT_W-1:0]    r_fail_count;
    logic [CNT_W-1:0]    r_cycle_count;
    logic [ADDR_W-1:0]   r_fail_addr;

    logic [MEM_W-1:0]    w_rd_word;
    logic [INSTR_W-1:0]  w_rd_instr;
    logic [RESULT_W-1:0] w_rd_expect;
    logic                w_rd_check;
    logic [ADDR_W:0]     w_pc_next_ext;
    logic                w_last;
    logic                w_mismatch;
    logic                w_start_ok;
    logic                w_we;

    // Loads are only honoured while no run is in progress.
    assign w_we = bus.load_en && !busy;

    mips32_prog_mem #(
        .DEPTH  (DEPTH),
        .W      (MEM_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (bus.load_addr),
        .i_wdata ({bus.load_check, bus.load_expect, bus.load_instr}),
        .i_raddr (r_pc),
        .o_rdata (w_rd_word)
    );

    assign {w_rd_check, w_rd_expect, w_rd_instr} = w_rd_word;

    // Last entry when pc+1 reaches prog_len (widened so DEPTH-1 cannot wrap).
    assign w_pc_next_ext = {1'b0, r_pc} + (ADDR_W+1)'(1);
    assign w_last        = (w_pc_next_ext >= prog_len);
    assign w_mismatch    = (r_state == ST_CHECK) && w_rd_check && (bus.result != w_rd_expect);
    assign w_start_ok    = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    assign fail_count  = r_fail_count;
    assign fail_addr   = r_fail_addr;
    assign cycle_count = r_cycle_count;
    assign o_dbg_state = r_state;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode (abort wins over everything) and state-based outputs.
    always_comb begin
        w_next          = r_state;
        bus.instruction = INSTR_W'(NOP_INSTR);
        bus.instr_valid = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        pass            = 1'b0;

        if (abort) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: if (start) w_next = (prog_len != '0) ? ST_ISSUE : ST_DONE;
                ST_ISSUE:         w_next = ST_SETTLE;
                ST_SETTLE:        if (r_settle == '0) w_next = ST_CHECK;
                ST_CHECK: begin
                    if (w_last)         w_next = ST_DONE;
                    else if (step_mode) w_next = ST_PAUSE;
                    else                w_next = ST_ISSUE;
                end
                ST_PAUSE:         if (step || !step_mode) w_next = ST_ISSUE;
                default:          w_next = ST_IDLE;
            endcase
        end

        case (r_state)
            ST_ISSUE, ST_SETTLE, ST_CHECK: begin
                bus.instruction = w_rd_instr;
                bus.instr_valid = 1'b1;
                busy            = 1'b1;
            end
            ST_PAUSE: busy = 1'b1;
            ST_DONE: begin
                done = 1'b1;
                pass = (r_fail_count == '0);
            end
            default: ;
        endcase
    end

    // Program counter, settle timer and result statistics; abort freezes them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= '0;
            r_settle      <= '0;
            r_fail_count  <= '0;
            r_fail_addr   <= '0;
            r_cycle_count <= '0;
        end else if (!abort) begin
            if (w_start_ok) begin
                r_pc          <= '0;
                r_fail_count  <= '0;
                r_fail_addr   <= '0;
                r_cycle_count <= '0;
            end else begin
                if (busy && (r_cycle_count != CNT_MAX)) begin
                    r_cycle_count <= r_cycle_count + CNT_W'(1);
                end
                if (r_state == ST_ISSUE) begin
                    r_settle <= SC_W'(SETTLE - 1);
                end else if ((r_state == ST_SETTLE) && (r_settle != '0)) begin
                    r_settle <= r_settle - SC_W'(1);
                end
                if (w_mismatch) begin
                    // fail_count never returns to zero once saturated, so zero means "first failure".
                    if (r_fail_count == '0) r_fail_addr <= r_pc;
                    if (r_fail_count != CNT_MAX) r_fail_count <= r_fail_count + CNT_W'(1);
                end
                if ((r_state == ST_CHECK) && !w_last) begin
                    r_pc <= r_pc + ADDR_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/mips32_program_sequencer.md
# mips32_program_sequencer

Synthesizable, parametrised instruction sequencer and result checker for the single-cycle MIPS32 core. Holds a loadable program of instructions with per-entry expected results, issues them to the core one at a time, waits a programmable settle interval, compares the core's `result` against the expected value, and reports pass/fail, first failing address and cycle count. It replaces hand-timed `#10` instruction driving with a reusable block usable in simulation and on FPGA bring-up.

## Interface
Parameters:
- `INSTR_W`, 32, instruction width
- `RESULT_W`, 32, core result width
- `DEPTH`, 64, program entries
- `ADDR_W`, `$clog2(DEPTH)`, program address width
- `SETTLE`, 1, wait cycles between issue and check (≥1)
- `CNT_W`, 16, width of fail and cycle counters

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `load_en` in 1: write program entry this cycle
- `load_addr` in ADDR_W: entry address
- `load_instr` in INSTR_W: instruction word
- `load_expect` in RESULT_W: expected result
- `load_check` in 1: 1 = compare this entry, 0 = issue only
- `prog_len` in ADDR_W+1: number of entries to run (0 = nothing)
- `start` in 1: begin run (pulse)
- `abort` in 1: return to IDLE
- `step_mode` in 1: 1 = pause after each entry
- `step` in 1: advance one entry while paused (pulse)
- `instruction` out INSTR_W: to core
- `instr_valid` out 1: `instruction` is a program entry
- `result` in RESULT_W: from core
- `busy`, `done`, `pass` out 1 each
- `fail_count` out CNT_W: mismatches, saturating
- `fail_addr` out ADDR_W: address of first mismatch
- `cycle_count` out CNT_W: cycles from start to done, saturating

## Operation
- States: IDLE, ISSUE, SETTLE, CHECK, PAUSE, DONE.
- IDLE: `start` with `prog_len`≠0 → ISSUE, pc=0, counters cleared. `start` with `prog_len`=0 → DONE, pass=1.
- ISSUE: `instruction`=mem[pc], `instr_valid`=1; → SETTLE.
- SETTLE: hold instruction for SETTLE cycles (down-counter); → CHECK.
- CHECK: instruction still held; if check bit set and `result`≠expect[pc]: fail_count+1 (saturate at all-ones), fail_addr=pc if first failure. Then: pc==prog_len−1 → DONE; else pc+1 and step_mode → PAUSE, else → ISSUE.
- PAUSE: `instr_valid`=0; `step` → ISSUE. `step_mode` deasserted while paused → ISSUE.
- DONE: `done`=1, `pass`=(fail_count==0); holds results until `start` (restart) or `abort`.
- `abort` in any state → IDLE next cycle, outputs to reset values except counters/fail_addr, which hold.
- `load_en` accepted only in IDLE or DONE; ignored (no write) when `busy`.
- Outside ISSUE/SETTLE/CHECK: `instruction`=0 (NOP), `instr_valid`=0.
- `cycle_count` increments every cycle while `busy`.

## Timing
- Reset: state IDLE, `instruction`=0, `instr_valid`=0, `busy`=0, `done`=0, `pass`=0, `fail_count`=0, `fail_addr`=0, `cycle_count`=0, pc=0. Program memory not reset.
- `start` sampled in IDLE → ISSUE on next edge; `busy` high from that edge.
- Per entry (free-run): 1 + SETTLE + 1 cycles; full run = prog_len×(SETTLE+2) cycles, equal to final `cycle_count`.
- `result` sampled at the CHECK clock edge (end of CHECK cycle); core must be combinational within SETTLE+1 cycles.
- `abort` has priority over `start`, `step`, state transitions; `start` during busy ignored.
- Load write is synchronous; an entry written in cycle t is issuable from t+1.

## Structure
- Package `mips32_seq_pkg`: state enum, `NOP_INSTR` = 0, default parameter constants.
- One sub-module: `mips32_prog_mem` — DEPTH×(INSTR_W+RESULT_W+1) synchronous-write, asynchronous-read storage.
- FSM, settle counter, pc and checker in the top.

## Test plan
- Load 2 entries (0x02119020 expect 0x5, 0x8C0D0062 expect 0x7), mock core returns matching values, SETTLE=1 → done after 6 cycles, pass=1, fail_count=0, cycle_count=6.
- Same program, mock returns 0x9 on entry 1 → pass=0, fail_count=1, fail_addr=1.
- step_mode=1, 3 entries → PAUSE after each, instr_valid=0, advances only on each `step` pulse; done after 2 steps.
- `abort` mid-SETTLE of entry 2 → IDLE next cycle, instruction=0, busy=0; new `start` reruns from pc=0.
- `load_en` while busy → memory unchanged (rerun gives identical result); prog_len=0 `start` → done=1, pass=1 next cycle.
- Assert `rst_n` low mid-run → all outputs to reset values immediately, asynchronously.
